// File: rtl/fifo_dest.sv
// Per-destination output buffer behind the 1:2 destination demux.
// Holds DEPTH words of DATA_W bits. Read data is registered, so a pop
// sampled on one edge shows up on data_out/valid_out in the next cycle.
// A push may still be accepted while the buffer is full, provided a pop
// is accepted on the same edge. A push that has to be dropped sets the
// sticky error flag, which only reset clears.
module fifo_dest #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] data_in,
   input  logic              push,
   input  logic              pop,
   input  logic [PTR_W:0]    umbral_alto,
   input  logic [PTR_W:0]    umbral_bajo,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              error
);

   localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              pop_ok;
   logic              push_ok;

   // Accept decisions and status flags, all derived from the registered count
   always_comb begin
      full         = (count == DEPTH_CNT);
      empty        = (count == '0);
      almost_full  = (count >= umbral_alto);
      almost_empty = (count <= umbral_bajo);
      pop_ok       = pop && !empty;
      // a pop on the same edge frees a slot, so a full buffer can still take a push
      push_ok      = push && (!full || pop_ok);
   end

   // Storage array; not reset, because only written entries are ever read
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers, occupancy count, registered read port and sticky overflow flag
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         error     <= 1'b0;
      end else begin
         valid_out <= pop_ok;
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !push_ok) begin
            error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_dest.sv
// Directed bench for fifo_dest. The internal count is observed through the
// live thresholds: count == k exactly when almost_full and almost_empty are
// both high with umbral_alto = umbral_bajo = k.
module tb_fifo_dest;

   logic       clk;
   logic       reset_L;
   logic [7:0] data_in;
   logic       push;
   logic       pop;
   logic [2:0] umbral_alto;
   logic [2:0] umbral_bajo;
   logic [7:0] data_out;
   logic       valid_out;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic       error;

   int checks = 0;
   int errors = 0;

   fifo_dest #(.DATA_W(8), .DEPTH(4), .PTR_W(2)) dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .data_in      (data_in),
      .push         (push),
      .pop          (pop),
      .umbral_alto  (umbral_alto),
      .umbral_bajo  (umbral_bajo),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .error        (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // probe the occupancy through the live thresholds, then restore them
   task automatic chk_cnt(input string tag, input int exp);
      logic [2:0] sa;
      logic [2:0] sb;
      sa = umbral_alto;
      sb = umbral_bajo;
      umbral_alto = exp[2:0];
      umbral_bajo = exp[2:0];
      #1;
      chk(tag, {almost_full, almost_empty}, 2'b11);
      umbral_alto = sa;
      umbral_bajo = sb;
   endtask

   // drive one cycle of stimulus; returns 1 time unit after the active edge
   task automatic step(input logic p, input logic q, input logic [7:0] d);
      push    = p;
      pop     = q;
      data_in = d;
      @(posedge clk);
      #1;
      push    = 1'b0;
      pop     = 1'b0;
   endtask

   task automatic do_reset();
      reset_L = 1'b0;
      #2;
      reset_L = 1'b1;
   endtask

   initial begin
      logic [7:0] fill_words [4];
      logic [7:0] b_words [4];
      fill_words[0] = 8'h0F; fill_words[1] = 8'h01;
      fill_words[2] = 8'h03; fill_words[3] = 8'h07;
      b_words[0] = 8'hB0; b_words[1] = 8'hB1;
      b_words[2] = 8'hB2; b_words[3] = 8'hB3;

      reset_L     = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      data_in     = 8'h00;
      umbral_alto = 3'd3;
      umbral_bajo = 3'd1;

      // 1. reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", data_out, 8'h00);
      chk("rst_valid", valid_out, 1'b0);
      chk("rst_full", full, 1'b0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_afull", almost_full, 1'b0);
      chk("rst_error", error, 1'b0);
      reset_L = 1'b1;

      // reset mid-fill acts immediately, without a clock edge
      step(1, 0, 8'hA0);
      step(1, 0, 8'hA1);
      step(1, 0, 8'hA2);
      chk_cnt("midfill_cnt3", 3);
      reset_L = 1'b0;
      #1;
      chk("async_rst_empty", empty, 1'b1);
      chk_cnt("async_rst_cnt0", 0);
      reset_L = 1'b1;

      // 2. fill with thresholds alto=3, bajo=1
      step(1, 0, 8'h0F);
      chk("fill1_empty", empty, 1'b0);
      chk("fill1_aempty", almost_empty, 1'b1);
      chk("fill1_afull", almost_full, 1'b0);
      step(1, 0, 8'h01);
      chk("fill2_aempty", almost_empty, 1'b0);
      chk("fill2_afull", almost_full, 1'b0);
      step(1, 0, 8'h03);
      chk("fill3_afull", almost_full, 1'b1);
      chk("fill3_full", full, 1'b0);
      step(1, 0, 8'h07);
      chk("fill4_full", full, 1'b1);
      chk("fill4_valid", valid_out, 1'b0);
      umbral_bajo = 3'd4;
      #1;
      chk("bajo4_aempty", almost_empty, 1'b1);
      umbral_bajo = 3'd1;

      // 3. overflow: dropped word, sticky error
      step(1, 0, 8'hAA);
      chk("ovf_error", error, 1'b1);
      chk("ovf_full", full, 1'b1);
      chk_cnt("ovf_cnt4", 4);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 8'h00);
         chk($sformatf("drain%0d_valid", i), valid_out, 1'b1);
         chk($sformatf("drain%0d_data", i), data_out, fill_words[i]);
         chk($sformatf("drain%0d_error", i), error, 1'b1);
      end
      chk("drained_empty", empty, 1'b1);
      step(0, 0, 8'h00);
      chk("idle_valid", valid_out, 1'b0);
      chk("idle_hold", data_out, 8'h07);
      umbral_alto = 3'd0;
      #1;
      chk("alto0_afull", almost_full, 1'b1);
      umbral_alto = 3'd3;

      // 4. wrap-around with count held at 2
      do_reset();
      chk("clr_error", error, 1'b0);
      step(1, 0, 8'h00);
      step(1, 0, 8'h01);
      for (int i = 2; i < 10; i++) begin
         step(1, 1, i[7:0]);
         chk($sformatf("wrap%0d_valid", i), valid_out, 1'b1);
         chk($sformatf("wrap%0d_data", i), data_out, i[7:0] - 8'd2);
         chk_cnt($sformatf("wrap%0d_cnt", i), 2);
      end
      step(0, 1, 8'h00);
      chk("wrap_tail8", data_out, 8'h08);
      step(0, 1, 8'h00);
      chk("wrap_tail9", data_out, 8'h09);
      chk("wrap_empty", empty, 1'b1);

      // 5. simultaneous push+pop while full, then while empty
      for (int i = 0; i < 4; i++) step(1, 0, b_words[i]);
      chk("sim_full_pre", full, 1'b1);
      step(1, 1, 8'h55);
      chk("simfull_valid", valid_out, 1'b1);
      chk("simfull_data", data_out, 8'hB0);
      chk("simfull_full", full, 1'b1);
      chk("simfull_error", error, 1'b0);
      for (int i = 1; i < 4; i++) begin
         step(0, 1, 8'h00);
         chk($sformatf("simdrain%0d", i), data_out, b_words[i]);
      end
      step(0, 1, 8'h00);
      chk("sim_last55", data_out, 8'h55);
      chk("sim_last_empty", empty, 1'b1);
      step(1, 1, 8'h33);
      chk("simempty_valid", valid_out, 1'b0);
      chk("simempty_hold", data_out, 8'h55);
      chk_cnt("simempty_cnt1", 1);
      step(0, 1, 8'h00);
      chk("simempty_pop", data_out, 8'h33);
      chk("simempty_pop_v", valid_out, 1'b1);

      // 6. underflow
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 8'h00);
         chk($sformatf("udf%0d_valid", i), valid_out, 1'b0);
         chk($sformatf("udf%0d_data", i), data_out, 8'h33);
         chk($sformatf("udf%0d_empty", i), empty, 1'b1);
         chk($sformatf("udf%0d_error", i), error, 1'b0);
      end
      chk_cnt("udf_cnt0", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
